// File: rtl/ysyx_22040175_lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 width codes,
// FSM state encoding and the base byte-enable pattern per access size.
package ysyx_22040175_lsu_pkg;

  localparam int unsigned CPU_WIDTH = 64;
  localparam int unsigned MASK_W    = 8;
  localparam int unsigned OFF_W     = 3;
  localparam int unsigned RD_W      = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_DONE
  } lsu_state_e;

  // Unshifted byte enables for an access of 1, 2, 4 or 8 bytes.
  function automatic logic [MASK_W-1:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040175_lsu_align.sv
// Combinational byte-lane alignment: store mask/data placement, load
// extraction with sign/zero extension, and natural-alignment check.
module ysyx_22040175_lsu_align
  import ysyx_22040175_lsu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_WIDTH
) (
  input  logic [2:0]        funct3,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [MASK_W-1:0] wmask_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic [DATA_W-1:0] rdata_c,
  output logic              misalign_c
);

  logic [5:0]        sh;
  logic [DATA_W-1:0] rsh;

  assign sh      = {off, 3'b000};
  assign wmask_c = MASK_W'(size_mask(funct3[1:0]) << off);
  assign wdata_c = wdata << sh;
  assign rsh     = rdata >> sh;

  always_comb begin
    misalign_c = 1'b0;
    case (funct3[1:0])
      2'b01:   misalign_c = off[0];
      2'b10:   misalign_c = |off[1:0];
      2'b11:   misalign_c = |off;
      default: misalign_c = 1'b0;
    endcase
  end

  always_comb begin
    rdata_c = '0;
    case (funct3)
      F3_B:    rdata_c = {{(DATA_W-8){rsh[7]}}, rsh[7:0]};
      F3_H:    rdata_c = {{(DATA_W-16){rsh[15]}}, rsh[15:0]};
      F3_W:    rdata_c = {{(DATA_W-32){rsh[31]}}, rsh[31:0]};
      F3_D:    rdata_c = rsh;
      F3_BU:   rdata_c = DATA_W'(rsh[7:0]);
      F3_HU:   rdata_c = DATA_W'(rsh[15:0]);
      F3_WU:   rdata_c = DATA_W'(rsh[31:0]);
      default: rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22040175_lsu.sv
// Multi-cycle load/store unit: one aligned 64-bit valid/ready bus transaction
// per memory op, results handed to write-back through a valid/ready port.
module ysyx_22040175_lsu
  import ysyx_22040175_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = CPU_WIDTH,
  parameter int unsigned DATA_W = CPU_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_ren,
  input  logic              ex_wen,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [RD_W-1:0]   ex_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_wen,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_rdata,
  output logic              wb_err
);

  lsu_state_e        state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              load_q, load_d;
  logic              ex_ready_d, req_valid_d, req_we_d;
  logic [ADDR_W-1:0] req_addr_d;
  logic [DATA_W-1:0] req_wdata_d;
  logic [MASK_W-1:0] req_wmask_d;
  logic              wb_valid_d, wb_wen_d, wb_err_d;
  logic [RD_W-1:0]   wb_rd_d;
  logic [DATA_W-1:0] wb_rdata_d;

  logic [2:0]        al_f3;
  logic [OFF_W-1:0]  al_off;
  logic [MASK_W-1:0] al_wmask;
  logic [DATA_W-1:0] al_wdata, al_rdata;
  logic              al_misalign;
  logic              illegal_c;

  // In IDLE the aligner decodes the incoming op; afterwards the latched one.
  assign al_f3  = (state_q == LSU_IDLE) ? ex_funct3 : f3_q;
  assign al_off = (state_q == LSU_IDLE) ? ex_addr[OFF_W-1:0] : off_q;

  ysyx_22040175_lsu_align #(.DATA_W(DATA_W)) u_align (
    .funct3     (al_f3),
    .off        (al_off),
    .wdata      (ex_wdata),
    .rdata      (mem_resp_rdata),
    .wmask_c    (al_wmask),
    .wdata_c    (al_wdata),
    .rdata_c    (al_rdata),
    .misalign_c (al_misalign)
  );

  assign illegal_c = (ex_ren || ex_wen) &&
                     (al_misalign || (ex_ren && ex_wen) ||
                      (ex_wen && ex_funct3[2]) || (ex_ren && ex_funct3 == 3'b111));

  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    off_d       = off_q;
    load_d      = load_q;
    ex_ready_d  = ex_ready;
    req_valid_d = mem_req_valid;
    req_we_d    = mem_req_we;
    req_addr_d  = mem_req_addr;
    req_wdata_d = mem_req_wdata;
    req_wmask_d = mem_req_wmask;
    wb_valid_d  = wb_valid;
    wb_wen_d    = wb_wen;
    wb_err_d    = wb_err;
    wb_rd_d     = wb_rd;
    wb_rdata_d  = wb_rdata;
    case (state_q)
      LSU_IDLE: begin
        if (ex_valid) begin
          ex_ready_d = 1'b0;
          f3_d       = ex_funct3;
          off_d      = ex_addr[OFF_W-1:0];
          load_d     = ex_ren;
          wb_rd_d    = ex_rd;
          wb_rdata_d = '0;
          wb_wen_d   = 1'b0;
          wb_err_d   = illegal_c;
          if (illegal_c || (!ex_ren && !ex_wen)) begin
            wb_valid_d = 1'b1;
            state_d    = LSU_DONE;
          end else begin
            req_valid_d = 1'b1;
            req_we_d    = ex_wen;
            req_addr_d  = {ex_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            req_wdata_d = ex_wen ? al_wdata : '0;
            req_wmask_d = ex_wen ? al_wmask : '0;
            state_d     = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        if (mem_resp_valid) begin
          if (load_q) begin
            wb_rdata_d = al_rdata;
            wb_wen_d   = 1'b1;
          end
          wb_valid_d = 1'b1;
          state_d    = LSU_DONE;
        end
      end
      LSU_DONE: begin
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          ex_ready_d = 1'b1;
          state_d    = LSU_IDLE;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= LSU_IDLE;
      f3_q          <= '0;
      off_q         <= '0;
      load_q        <= 1'b0;
      ex_ready      <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      wb_valid      <= 1'b0;
      wb_wen        <= 1'b0;
      wb_err        <= 1'b0;
      wb_rd         <= '0;
      wb_rdata      <= '0;
    end else begin
      state_q       <= state_d;
      f3_q          <= f3_d;
      off_q         <= off_d;
      load_q        <= load_d;
      ex_ready      <= ex_ready_d;
      mem_req_valid <= req_valid_d;
      mem_req_we    <= req_we_d;
      mem_req_addr  <= req_addr_d;
      mem_req_wdata <= req_wdata_d;
      mem_req_wmask <= req_wmask_d;
      wb_valid      <= wb_valid_d;
      wb_wen        <= wb_wen_d;
      wb_err        <= wb_err_d;
      wb_rd         <= wb_rd_d;
      wb_rdata      <= wb_rdata_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040175_lsu.sv
// Self-checking bench for the LSU: directed cases then randomized ops,
// compared against an arithmetic reference model of the access rules.
module tb_ysyx_22040175_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_ren, ex_wen;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        wb_valid, wb_ready, wb_wen, wb_err;
  logic [4:0]  wb_rd;
  logic [63:0] wb_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ysyx_22040175_lsu dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_ren         (ex_ren),
    .ex_wen         (ex_wen),
    .ex_funct3      (ex_funct3),
    .ex_addr        (ex_addr),
    .ex_wdata       (ex_wdata),
    .ex_rd          (ex_rd),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_wen         (wb_wen),
    .wb_rd          (wb_rd),
    .wb_rdata       (wb_rdata),
    .wb_err         (wb_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Access rules as plain arithmetic: size in bytes, byte offset, modular extension.
  task automatic model(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                       output logic err, output logic nop, output logic [7:0] m,
                       output logic [63:0] wd, output logic [63:0] ext);
    int unsigned nbytes, off;
    logic [63:0] v, lim;
    nbytes = 1 << f3[1:0];
    off    = int'(addr % 8);
    nop    = !ren && !wen;
    err    = !nop && ((ren && wen) || (wen && f3[2]) || (ren && f3 == 3'b111) ||
                      (addr % nbytes != 0));
    m      = 8'(((1 << nbytes) - 1) << off);
    wd     = wdata << (8 * off);
    v      = rdata >> (8 * off);
    if (nbytes < 8) begin
      lim = 64'd1 << (8 * nbytes);
      v   = v % lim;
      if (!f3[2] && v >= lim / 2) v = v - lim;
    end
    ext = v;
  endtask

  task automatic do_op(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                       input logic [63:0] rdata, input int req_wait, input int resp_wait,
                       input int wb_wait);
    logic err, nop;
    logic [7:0] m;
    logic [63:0] wd, ext;
    model(ren, wen, f3, addr, wdata, rdata, err, nop, m, wd, ext);
    @(negedge clk);
    check("ex_ready_idle", 64'(ex_ready), 64'd1);
    ex_valid = 1'b1; ex_ren = ren; ex_wen = wen; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
    @(negedge clk);
    ex_valid = 1'b0; ex_ren = $urandom_range(0, 1) != 0; ex_wen = $urandom_range(0, 1) != 0;
    ex_addr = {$urandom, $urandom}; ex_wdata = {$urandom, $urandom};
    if (!(err || nop)) begin
      for (int i = 0; i <= req_wait; i++) begin
        check("req_valid", 64'(mem_req_valid), 64'd1);
        check("req_we", 64'(mem_req_we), 64'(wen));
        check("req_addr", mem_req_addr, {addr[63:3], 3'b000});
        if (wen) begin
          check("req_wmask", 64'(mem_req_wmask), 64'(m));
          check("req_wdata", mem_req_wdata, wd);
        end
        check("req_ex_ready", 64'(ex_ready), 64'd0);
        check("req_wb_valid", 64'(wb_valid), 64'd0);
        mem_req_ready  = (i == req_wait);
        mem_resp_valid = (i < req_wait) && ($urandom_range(0, 1) != 0);
        mem_resp_rdata = {$urandom, $urandom};
        @(negedge clk);
      end
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      for (int j = 0; j < resp_wait; j++) begin
        check("wait_req_valid", 64'(mem_req_valid), 64'd0);
        check("wait_wb_valid", 64'(wb_valid), 64'd0);
        @(negedge clk);
      end
      mem_resp_valid = 1'b1;
      mem_resp_rdata = rdata;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_rdata = {$urandom, $urandom};
    end
    for (int k = 0; k <= wb_wait; k++) begin
      check("wb_valid", 64'(wb_valid), 64'd1);
      check("wb_wen", 64'(wb_wen), 64'(ren && !err && !nop));
      check("wb_err", 64'(wb_err), 64'(err));
      check("wb_rd", 64'(wb_rd), 64'(rd));
      check("wb_rdata", wb_rdata, (ren && !err && !nop) ? ext : 64'd0);
      check("done_ex_ready", 64'(ex_ready), 64'd0);
      check("done_req_valid", 64'(mem_req_valid), 64'd0);
      wb_ready = (k == wb_wait);
      @(negedge clk);
    end
    wb_ready = 1'b0;
    check("wb_valid_clear", 64'(wb_valid), 64'd0);
    check("ex_ready_back", 64'(ex_ready), 64'd1);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [63:0] a;
    int          kind;
    rst = 1'b1; ex_valid = 1'b0; ex_ren = 1'b0; ex_wen = 1'b0; ex_funct3 = '0;
    ex_addr = '0; ex_wdata = '0; ex_rd = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_rdata = '0; wb_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ex_ready", 64'(ex_ready), 64'd1);
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_wen", 64'(wb_wen), 64'd0);
    check("rst_wb_err", 64'(wb_err), 64'd0);
    check("rst_wb_rdata", wb_rdata, 64'd0);
    check("rst_req_addr", mem_req_addr, 64'd0);

    // Directed cases.
    do_op(1'b0, 1'b1, 3'b011, 64'h8000_0008, 64'h1122_3344_5566_7788, 5'd3, 64'd0, 0, 0, 0);
    do_op(1'b0, 1'b1, 3'b000, 64'h8000_0003, 64'h0000_0000_0000_00AB, 5'd4, 64'd0, 0, 0, 0);
    do_op(1'b1, 1'b0, 3'b000, 64'h8000_0005, 64'h0000_8000_0000_0000, 5'd10, 64'h0000_8000_0000_0000, 0, 0, 0);
    do_op(1'b1, 1'b0, 3'b100, 64'h8000_0005, 64'h0, 5'd11, 64'h0000_8000_0000_0000, 0, 0, 0);
    do_op(1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'h0, 5'd12, 64'h0, 0, 0, 0);
    do_op(1'b1, 1'b0, 3'b001, 64'h8000_0006, 64'h0, 5'd13, 64'h8001_7FFF_1234_5678, 3, 1, 2);
    do_op(1'b0, 1'b0, 3'b011, 64'h8000_0001, 64'h0, 5'd14, 64'h0, 0, 0, 1);
    do_op(1'b1, 1'b1, 3'b000, 64'h8000_0000, 64'h0, 5'd15, 64'h0, 0, 0, 0);
    do_op(1'b0, 1'b1, 3'b100, 64'h8000_0000, 64'h0, 5'd16, 64'h0, 0, 0, 0);
    do_op(1'b1, 1'b0, 3'b111, 64'h8000_0000, 64'h0, 5'd17, 64'h0, 0, 0, 0);

    // Reset while a request is pending, then a stale response.
    @(negedge clk);
    ex_valid = 1'b1; ex_ren = 1'b1; ex_wen = 1'b0; ex_funct3 = 3'b011;
    ex_addr = 64'h8000_0010; ex_rd = 5'd7;
    @(negedge clk);
    ex_valid = 1'b0;
    check("pre_rst_req_valid", 64'(mem_req_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_mid_wb_rd", 64'(wb_rd), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_resp_wb_valid", 64'(wb_valid), 64'd0);
      check("late_resp_ex_ready", 64'(ex_ready), 64'd1);
      @(negedge clk);
    end

    // Randomized ops.
    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 9));
      f3   = 3'($urandom_range(0, 7));
      a    = {32'h8000_0000, $urandom};
      if ($urandom_range(0, 2) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
      do_op((kind >= 2 && kind <= 5) || kind == 1, kind >= 6 || kind == 1, f3, a,
            {$urandom, $urandom}, 5'($urandom_range(0, 31)), {$urandom, $urandom},
            int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
